// File: rtl/candidate_select_pkg.sv
// Shared width helpers and FSM encoding for the candidate_select block.
package candidate_select_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPT,
    ST_MSQ,
    ST_CMP,
    ST_DONE
  } state_t;

  function automatic int xw(input int n);
    return 4 * n + 10;
  endfunction

  function automatic int yw(input int n);
    return 3 * n + 7;
  endfunction

  function automatic int mw(input int n);
    return xw(n) + 1;
  endfunction

endpackage

// File: rtl/candidate_select_mult.sv
// seq_mult_u: unsigned shift-add multiplier, W iterations per product, one-cycle done pulse.
module seq_mult_u #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] product,
  output logic           done
);

  localparam int CW = $clog2(W + 1);

  logic [2*W-1:0] mcand;
  logic [W-1:0]   mplier;
  logic [CW-1:0]  cnt;
  logic           busy;

  // The last iteration raises done, so a product is ready W cycles after start is sampled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else if (start) begin
      mcand   <= {{W{1'b0}}, a};
      mplier  <= b;
      cnt     <= CW'(W);
      busy    <= 1'b1;
      product <= '0;
      done    <= 1'b0;
    end else if (busy) begin
      if (mplier[0])
        product <= product + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/candidate_select.sv
// Picks the intersection candidate whose distance to anchor A best matches rA.
// Optional err output (min residual) enabled by defining CANDSEL_ERR_OUT_EN.
module candidate_select
  import candidate_select_pkg::*;
#(
  parameter int N = 8,
  parameter int F = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [xw(N)-1:0] x1,
  input  logic signed [xw(N)-1:0] x2,
  input  logic signed [yw(N)-1:0] y1,
  input  logic signed [yw(N)-1:0] y2,
  input  logic signed [N-1:0]     xA,
  input  logic signed [N-1:0]     yA,
  input  logic [N:0]              rA,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [xw(N)-1:0] x_sel,
  output logic signed [yw(N)-1:0] y_sel,
  output logic                    sel
`ifdef CANDSEL_ERR_OUT_EN
  ,
  output logic [2*mw(N):0]        err
`endif
);

  localparam int XW = xw(N);
  localparam int YW = yw(N);
  localparam int MW = mw(N);
  localparam int PW = 2 * MW;
  localparam int SW = 2 * MW + 1;

  state_t state;

  logic signed [XW-1:0] x1_q, x2_q;
  logic signed [YW-1:0] y1_q, y2_q;
  logic signed [N-1:0]  xa_q, ya_q;
  logic [N:0]           ra_q;

  logic signed [MW-1:0] xa_s, ya_s, dx1, dy1, dx2, dy2;
  logic [MW-1:0]        r_s;
  logic [MW-1:0]        mag [5];
  logic [PW-1:0]        sq [5];
  logic [2:0]           sq_idx;
  logic [2:0]           op_idx;
  logic [MW-1:0]        mult_op;
  logic                 mult_start;
  logic [PW-1:0]        mult_product;
  logic                 mult_done;
  logic [SW-1:0]        s1, s2, r2, e1, e2;
  logic                 pick2;

  function automatic logic [MW-1:0] abs_mw(input logic [MW-1:0] v);
    return v[MW-1] ? (~v + 1'b1) : v;
  endfunction

  // Differences are taken at MW bits so the most negative inputs cannot overflow.
  assign xa_s = {{(MW-N){xa_q[N-1]}}, xa_q} <<< F;
  assign ya_s = {{(MW-N){ya_q[N-1]}}, ya_q} <<< F;
  assign dx1  = {{(MW-XW){x1_q[XW-1]}}, x1_q} - xa_s;
  assign dx2  = {{(MW-XW){x2_q[XW-1]}}, x2_q} - xa_s;
  assign dy1  = {{(MW-YW){y1_q[YW-1]}}, y1_q} - ya_s;
  assign dy2  = {{(MW-YW){y2_q[YW-1]}}, y2_q} - ya_s;
  assign r_s  = {{(MW-N-1){1'b0}}, ra_q} << F;

  always_comb begin
    mag[0] = abs_mw(dx1);
    mag[1] = abs_mw(dy1);
    mag[2] = abs_mw(dx2);
    mag[3] = abs_mw(dy2);
    mag[4] = r_s;
  end

  always_comb begin
    mult_start = 1'b0;
    op_idx     = 3'd0;
    if (state == ST_CAPT) begin
      mult_start = 1'b1;
    end else if (state == ST_MSQ && mult_done && sq_idx != 3'd4) begin
      mult_start = 1'b1;
      op_idx     = sq_idx + 3'd1;
    end
  end

  always_comb begin
    case (op_idx)
      3'd0:    mult_op = mag[0];
      3'd1:    mult_op = mag[1];
      3'd2:    mult_op = mag[2];
      3'd3:    mult_op = mag[3];
      default: mult_op = mag[4];
    endcase
  end

  seq_mult_u #(.W(MW)) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .a       (mult_op),
    .b       (mult_op),
    .product (mult_product),
    .done    (mult_done)
  );

  assign s1    = {1'b0, sq[0]} + {1'b0, sq[1]};
  assign s2    = {1'b0, sq[2]} + {1'b0, sq[3]};
  assign r2    = {1'b0, sq[4]};
  assign e1    = (s1 >= r2) ? (s1 - r2) : (r2 - s1);
  assign e2    = (s2 >= r2) ? (s2 - r2) : (r2 - s2);
  assign pick2 = (e2 < e1);

  // Results stay registered through DONE until the consumer takes them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      x_sel     <= '0;
      y_sel     <= '0;
      sel       <= 1'b0;
      sq_idx    <= '0;
      x1_q      <= '0;
      x2_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      xa_q      <= '0;
      ya_q      <= '0;
      ra_q      <= '0;
      for (int i = 0; i < 5; i++)
        sq[i] <= '0;
`ifdef CANDSEL_ERR_OUT_EN
      err       <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            x1_q     <= x1;
            x2_q     <= x2;
            y1_q     <= y1;
            y2_q     <= y2;
            xa_q     <= xA;
            ya_q     <= yA;
            ra_q     <= rA;
            in_ready <= 1'b0;
            state    <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          sq_idx <= '0;
          state  <= ST_MSQ;
        end
        ST_MSQ: begin
          if (mult_done) begin
            sq[sq_idx] <= mult_product;
            if (sq_idx == 3'd4)
              state <= ST_CMP;
            else
              sq_idx <= sq_idx + 3'd1;
          end
        end
        ST_CMP: begin
          sel       <= pick2;
          x_sel     <= pick2 ? x2_q : x1_q;
          y_sel     <= pick2 ? y2_q : y1_q;
`ifdef CANDSEL_ERR_OUT_EN
          err       <= pick2 ? e2 : e1;
`endif
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_candidate_select.sv
// Self-checking bench for candidate_select (N=8, F=0); checks err too when CANDSEL_ERR_OUT_EN is defined.
module tb_candidate_select;
  import candidate_select_pkg::*;

  localparam int N  = 8;
  localparam int F  = 0;
  localparam int XW = xw(N);
  localparam int YW = yw(N);
  localparam int SW = 2 * mw(N) + 1;
  localparam int LAT = 5 * (mw(N) + 1) + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [XW-1:0] x1 = '0, x2 = '0;
  logic signed [YW-1:0] y1 = '0, y2 = '0;
  logic signed [N-1:0]  xA = '0, yA = '0;
  logic [N:0]           rA = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic signed [XW-1:0] x_sel;
  logic signed [YW-1:0] y_sel;
  logic sel;
`ifdef CANDSEL_ERR_OUT_EN
  logic [SW-1:0] err;
`endif

  candidate_select #(.N(N), .F(F)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .y1        (y1),
    .y2        (y2),
    .xA        (xA),
    .yA        (yA),
    .rA        (rA),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_sel     (x_sel),
    .y_sel     (y_sel),
    .sel       (sel)
`ifdef CANDSEL_ERR_OUT_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic                 sel;
    logic signed [XW-1:0] xs;
    logic signed [YW-1:0] ys;
    logic [SW-1:0]        err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s did not hold", tag);
    end
  endtask

  function automatic exp_t model(input logic signed [XW-1:0] a1, input logic signed [YW-1:0] b1,
                                 input logic signed [XW-1:0] a2, input logic signed [YW-1:0] b2,
                                 input logic signed [N-1:0] xa, input logic signed [N-1:0] ya,
                                 input logic [N:0] ra);
    logic signed [127:0] dx1, dy1, dx2, dy2, rr, e1, e2;
    exp_t r;
    dx1 = 128'(a1) - (128'(xa) <<< F);
    dy1 = 128'(b1) - (128'(ya) <<< F);
    dx2 = 128'(a2) - (128'(xa) <<< F);
    dy2 = 128'(b2) - (128'(ya) <<< F);
    rr  = 128'(ra) <<< F;
    e1 = dx1 * dx1 + dy1 * dy1 - rr * rr;
    e2 = dx2 * dx2 + dy2 * dy2 - rr * rr;
    if (e1 < 0) e1 = -e1;
    if (e2 < 0) e2 = -e2;
    r.sel = (e2 < e1);
    r.xs  = r.sel ? a2 : a1;
    r.ys  = r.sel ? b2 : b1;
    r.err = r.sel ? SW'(e2) : SW'(e1);
    return r;
  endfunction

  task automatic applyStimulus(input logic signed [XW-1:0] a1, input logic signed [YW-1:0] b1,
                               input logic signed [XW-1:0] a2, input logic signed [YW-1:0] b2,
                               input logic signed [N-1:0] xa, input logic signed [N-1:0] ya,
                               input logic [N:0] ra);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", in_ready, 1'b1);
    x1 = a1; y1 = b1; x2 = a2; y2 = b2; xA = xa; yA = ya; rA = ra;
    in_valid = 1'b1;
    sb.push_back(model(a1, b1, a2, b2, xa, ya, ra));
    @(posedge clk);
    @(negedge clk);
    acc_cyc  = cyc;
    in_valid = 1'b0;
    // Scramble the inputs; the captured transaction must not notice.
    x1 = ~a1; y1 = ~b1; x2 = a1; y2 = b1; xA = ~xa; yA = ~ya; rA = ~ra;
    check("in_ready_after_accept", in_ready, 1'b0);
  endtask

  task automatic checkOutput(input int bp);
    int w = 0;
    logic busy_ready = 1'b0;
    logic stable = 1'b1;
    logic ready_seen = 1'b0;
    logic signed [XW-1:0] xs0;
    logic signed [YW-1:0] ys0;
    logic s0;
    exp_t e;
    while (!out_valid && w < LAT + 100) begin
      busy_ready |= in_ready;
      @(negedge clk);
      w++;
    end
    check("latency", 128'(cyc - acc_cyc), 128'(LAT));
    check("in_ready_busy", busy_ready, 1'b0);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    check("sel", sel, e.sel);
    check("x_sel", x_sel, e.xs);
    check("y_sel", y_sel, e.ys);
`ifdef CANDSEL_ERR_OUT_EN
    check("err", err, e.err);
`endif
    xs0 = x_sel; ys0 = y_sel; s0 = sel;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      stable &= (x_sel === xs0) && (y_sel === ys0) && (sel === s0) && (out_valid === 1'b1);
      ready_seen |= in_ready;
    end
    if (bp > 0) begin
      check("bp_stable", stable, 1'b1);
      check("bp_in_ready_low", ready_seen, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", out_valid, 1'b0);
    check("in_ready_return", in_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic signed [XW-1:0] xmin, xmax, rx1, rx2;
    logic signed [YW-1:0] ymin, ymax, ry1, ry2;
    logic saw_valid;

    xmin = '0; xmin[XW-1] = 1'b1; xmax = ~xmin;
    ymin = '0; ymin[YW-1] = 1'b1; ymax = ~ymin;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sel", sel, 1'b0);
    check("rst_x_sel", x_sel, '0);
    check("rst_y_sel", y_sel, '0);
    rst = 1'b1;
    #1;
    check("release_in_ready_low", in_ready, 1'b0);
    @(negedge clk);
    check("release_in_ready_high", in_ready, 1'b1);

    $display("[TB] basic selection");
    applyStimulus(3, 4, 6, 8, 0, 0, 5);
    checkOutput(0);

    $display("[TB] swapped candidates with backpressure");
    applyStimulus(6, 8, 3, 4, 0, 0, 5);
    checkOutput(10);

    $display("[TB] tie");
    applyStimulus(3, 4, -3, -4, 0, 0, 5);
    checkOutput(0);

    $display("[TB] reset mid-operation");
    applyStimulus(10, -7, 2, 1, 1, 1, 4);
    repeat (49) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b0);
    void'(sb.pop_back());
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready_return", in_ready, 1'b1);
    saw_valid = 1'b0;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      saw_valid |= out_valid;
    end
    check("abort_no_valid", saw_valid, 1'b0);

    $display("[TB] transaction after abort");
    applyStimulus(10, -7, 2, 1, 1, 1, 4);
    checkOutput(0);

    $display("[TB] extremes");
    applyStimulus(xmin, ymin, xmax, ymax, -128, -128, 511);
    checkOutput(0);
    applyStimulus(xmax, ymax, xmin, ymin, -128, -128, 511);
    checkOutput(2);

    $display("[TB] random small values");
    for (int k = 0; k < 3; k++) begin
      rx1 = XW'($signed($urandom_range(2000)) - 1000);
      rx2 = XW'($signed($urandom_range(2000)) - 1000);
      ry1 = YW'($signed($urandom_range(2000)) - 1000);
      ry2 = YW'($signed($urandom_range(2000)) - 1000);
      applyStimulus(rx1, ry1, rx2, ry2, N'($signed($urandom_range(200)) - 100),
                    N'($signed($urandom_range(200)) - 100), (N+1)'($urandom_range(511)));
      checkOutput(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
